axi_sram_rd_slave: RTL

- AXI read responder that connects one on-chip SRAM to the interconnect's AR and R channels on the slave side.
- Accepts one read address handshake at a time and reads the SRAM with 1-cycle synchronous latency.
- Returns a burst of R beats carrying RID, RDATA, RRESP and RLAST, upstream of the R-channel arbiter.
- Supports FIXED, INCR and WRAP bursts and full RREADY backpressure.

---
 rtl/axi_sram_rd_slave.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_rd_slave.sv
// ============================================================================
// Module   : axi_sram_rd_slave
// Brief    : AXI AR/R read responder in front of a single-port synchronous SRAM.
//            Optional build macro RD_ERR_RESP_EN enables DECERR/SLVERR responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sram_rd_slave #(
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 16384,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [IDS_W-1:0]  RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              sram_cs,
    output logic [AW-1:0]     sram_a,
    input  logic [DATA_W-1:0] sram_do
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    localparam logic [1:0] c_FIXED = 2'b00;
    localparam logic [1:0] c_WRAP  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              rdy_en_q;
    logic [IDS_W-1:0]  id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              cap_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_last;
    logic              w_beat_ok;
    logic [1:0]        w_rresp;
    logic [DATA_W-1:0] w_rdata;
    logic [LEN_W-1:0]  w_len_p1;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_bnd;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_ar_hs = ARVALID & ARREADY;
    assign w_last  = (cnt_q == '0);
    assign w_r_hs  = rvalid_q & RREADY & ~cap_q;

    // Beat-level error classification
`ifdef RD_ERR_RESP_EN
    logic w_in_range;
    logic w_size_err;
    assign w_in_range = (addr_q[ADDR_W-1:AW+2] == '0);
    assign w_size_err = (size_q > 3'd2);
    assign w_beat_ok  = w_in_range & ~w_size_err;
    assign w_rresp    = w_size_err ? 2'b10 : (w_in_range ? 2'b00 : 2'b11);
    assign w_rdata    = w_beat_ok ? sram_do : '0;
`else
    assign w_beat_ok  = 1'b1;
    assign w_rresp    = 2'b00;
    assign w_rdata    = sram_do;
`endif

    // WRAP is honoured only for power-of-two lengths of 2 or more beats
    assign w_len_p1 = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign w_wrap   = (burst_q == c_WRAP) && (len_q != '0) && ((len_q & w_len_p1) == '0);
    assign w_step   = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;
    assign w_bnd    = ({{(ADDR_W-LEN_W){1'b0}}, len_q} + {{(ADDR_W-1){1'b0}}, 1'b1}) << size_q;
    assign w_mask   = w_bnd - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_inc    = addr_q + w_step;

    always_comb begin
        w_addr_nxt = w_inc;
        if (burst_q == c_FIXED) begin
            w_addr_nxt = addr_q;
        end else if (w_wrap) begin
            w_addr_nxt = (addr_q & ~w_mask) | (w_inc & w_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (w_ar_hs) state_d = c_READ;
            c_READ: state_d = c_RESP;
            c_RESP: if (w_r_hs) state_d = w_last ? c_IDLE : c_READ;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = (state_q == c_IDLE) & rdy_en_q;
        sram_cs = (state_q == c_READ) & w_beat_ok;
    end

    // cap_q marks the cycle where SRAM data is valid but not yet presented
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cap_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                c_IDLE: begin
                    if (w_ar_hs) begin
                        id_q    <= ARID;
                        addr_q  <= ARADDR;
                        cnt_q   <= ARLEN;
                        len_q   <= ARLEN;
                        size_q  <= ARSIZE;
                        burst_q <= ARBURST;
                    end
                end
                c_READ: begin
                    cap_q <= 1'b1;
                end
                c_RESP: begin
                    if (cap_q) begin
                        cap_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= w_rdata;
                        rresp_q  <= w_rresp;
                    end else if (w_r_hs) begin
                        rvalid_q <= 1'b0;
                        if (!w_last) begin
                            cnt_q  <= cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
                            addr_q <= w_addr_nxt;
                        end
                    end
                end
                default: begin
                    cap_q <= 1'b0;
                end
            endcase
        end
    end

    assign sram_a = addr_q[AW+1:2];
    assign RID    = id_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
    assign RVALID = rvalid_q;
    assign RLAST  = rvalid_q & w_last;

endmodule

`default_nettype wire
